// File: rtl/bot_permuter_stream_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bot_permuter_stream_if
//   Bundles the two valid/ready streams of bot_permuter_stream: the burst
//   input stream (bot + permutation request mask + sideband) and the
//   permutation output stream (permuted bot + index + sideband + last flag).
//
//   Parameters
//     VAR_COUNT         bot variable count; bot width is 1 << VAR_COUNT
//     EXTRA_DATA_WIDTH  sideband width
//
//   Modports
//     master : bot source / downstream pipeline side (drives bursts, drives
//              outputReady, observes the permutation stream)
//     slave  : permuter side (accepts bursts, emits permutations)
// -----------------------------------------------------------------------------
interface bot_permuter_stream_if #(
  parameter int VAR_COUNT        = 7,
  parameter int EXTRA_DATA_WIDTH = 12
);
  localparam int BOT_WIDTH = 1 << VAR_COUNT;

  // Burst input stream
  logic                        inputValid;
  logic                        inputReady;
  logic [BOT_WIDTH-1:0]        botIn;
  logic [5:0]                  validBotPermutesIn;
  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn;

  // Permutation output stream
  logic                        outputValid;
  logic                        outputReady;
  logic [BOT_WIDTH-1:0]        permutedBot;
  logic [2:0]                  selectedPermutationOut;
  logic [EXTRA_DATA_WIDTH-1:0] extraDataOut;
  logic                        lastOfBurst;

  modport master (
    output inputValid, botIn, validBotPermutesIn, extraDataIn, outputReady,
    input  inputReady, outputValid, permutedBot, selectedPermutationOut,
           extraDataOut, lastOfBurst
  );

  modport slave (
    input  inputValid, botIn, validBotPermutesIn, extraDataIn, outputReady,
    output inputReady, outputValid, permutedBot, selectedPermutationOut,
           extraDataOut, lastOfBurst
  );
endinterface

// File: rtl/bot_permuter_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bot_permuter_stream
//   Streams every requested permutation of the top three variables of a bot,
//   one per cycle. A burst is a bot plus a 6-bit request mask
//   {ABC,ACB,BAC,BCA,CAB,CBA}; permutations are emitted highest mask bit
//   first. Two burst slots (active + pending) let the next burst load while
//   the current one drains, so consecutive bursts stream without a bubble.
//
//   The bot is viewed as eight parts of BOT_WIDTH/8 bits. Parts 0 and 7 pass
//   through; parts {1,2,4} and {6,5,3} are reordered according to the
//   emitted permutation index.
//
//   Ports
//     clk, rstn  clock, asynchronous active-low reset
//     s_if       stream interface (slave modport): burst in, permutation out
//     busy       any slot or the output register is occupied
//     burstCount, permutationCount, stallCycles
//                statistics counters, present only with
//                BOT_PERMUTER_STATS_EN defined
//
//   Configuration macro
//     BOT_PERMUTER_STATS_EN  adds the three wrap-around statistics counters
// -----------------------------------------------------------------------------
module bot_permuter_stream #(
  parameter int VAR_COUNT        = 7,
  parameter int EXTRA_DATA_WIDTH = 12
`ifdef BOT_PERMUTER_STATS_EN
  , parameter int STAT_WIDTH     = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rstn,
  bot_permuter_stream_if.slave   s_if,
  output logic                   busy
`ifdef BOT_PERMUTER_STATS_EN
  , output logic [STAT_WIDTH-1:0] burstCount
  , output logic [STAT_WIDTH-1:0] permutationCount
  , output logic [STAT_WIDTH-1:0] stallCycles
`endif
);

  localparam int BOT_WIDTH = 1 << VAR_COUNT;
  localparam int PART      = BOT_WIDTH / 8;

  typedef logic [BOT_WIDTH-1:0]        bot_t;
  typedef logic [EXTRA_DATA_WIDTH-1:0] extra_t;
  typedef logic [5:0]                  mask_t;

  // ---------------------------------------------------------------------------
  // Permutation datapath
  // ---------------------------------------------------------------------------
  function automatic logic [PART-1:0] f_pick(input logic [PART-1:0] a,
                                             input logic [PART-1:0] b,
                                             input logic [PART-1:0] c,
                                             input logic [1:0]      idx);
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  function automatic bot_t f_permute(input bot_t bot, input logic [2:0] sel);
    logic [PART-1:0] one0, one1, one2, two0, two1, two2;
    logic [1:0]      idx_f, idx_s, idx_t;
    bot_t            res;
    // one[] are the parts with a single top variable set, two[] their
    // complements; permuting the variables reorders both triples alike.
    one0 = bot[1*PART +: PART];
    one1 = bot[2*PART +: PART];
    one2 = bot[4*PART +: PART];
    two0 = bot[6*PART +: PART];
    two1 = bot[5*PART +: PART];
    two2 = bot[3*PART +: PART];
    case (sel)
      3'd4:    begin idx_f = 2'd0; idx_s = 2'd2; idx_t = 2'd1; end
      3'd3:    begin idx_f = 2'd1; idx_s = 2'd0; idx_t = 2'd2; end
      3'd2:    begin idx_f = 2'd1; idx_s = 2'd2; idx_t = 2'd0; end
      3'd1:    begin idx_f = 2'd2; idx_s = 2'd0; idx_t = 2'd1; end
      3'd0:    begin idx_f = 2'd2; idx_s = 2'd1; idx_t = 2'd0; end
      default: begin idx_f = 2'd0; idx_s = 2'd1; idx_t = 2'd2; end
    endcase
    res = bot;  // parts 0 and 7 pass through
    res[1*PART +: PART] = f_pick(one0, one1, one2, idx_f);
    res[2*PART +: PART] = f_pick(one0, one1, one2, idx_s);
    res[4*PART +: PART] = f_pick(one0, one1, one2, idx_t);
    res[6*PART +: PART] = f_pick(two0, two1, two2, idx_f);
    res[5*PART +: PART] = f_pick(two0, two1, two2, idx_s);
    res[3*PART +: PART] = f_pick(two0, two1, two2, idx_t);
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Active slot: a non-zero mask means the slot holds a burst.
  mask_t   r_act_mask;
  bot_t    r_act_bot;
  extra_t  r_act_extra;
  // Pending slot
  logic    r_pend_valid;
  mask_t   r_pend_mask;
  bot_t    r_pend_bot;
  extra_t  r_pend_extra;
  // Output register
  logic       r_out_valid;
  bot_t       r_out_bot;
  logic [2:0] r_out_sel;
  extra_t     r_out_extra;
  logic       r_out_last;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic       w_act_valid;
  logic [2:0] w_sel;
  mask_t      w_rem_mask;
  logic       w_advance;
  logic       w_emit;
  logic       w_emit_last;
  logic       w_act_free_next;
  logic       w_promote;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_accept_nz;
  logic       w_load_act;
  logic       w_load_pend;

  // Depends on registered state and rstn only, never on outputReady.
  assign w_in_ready = rstn & ~r_pend_valid;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_act_valid = |r_act_mask;
    w_sel       = 3'd0;
    // Ascending scan: the last hit is the highest set bit.
    for (int k = 0; k < 6; k++) begin
      if (r_act_mask[k]) w_sel = 3'(k);
    end
    w_rem_mask      = r_act_mask & ~(mask_t'(1) << w_sel);

    w_advance       = ~r_out_valid | s_if.outputReady;
    w_emit          = w_advance & w_act_valid;
    w_emit_last     = w_emit & (w_rem_mask == '0);
    // The active slot is free after this edge if it is empty now or its final
    // permutation leaves this edge; the pending burst then moves up.
    w_act_free_next = ~w_act_valid | w_emit_last;
    w_promote       = r_pend_valid & w_act_free_next;

    w_accept        = s_if.inputValid & w_in_ready;
    // An all-zero request mask is consumed without occupying a slot.
    w_accept_nz     = w_accept & (|s_if.validBotPermutesIn);
    w_load_act      = w_accept_nz & w_act_free_next & ~w_promote;
    w_load_pend     = w_accept_nz & ~w_load_act;
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act_mask   <= '0;
      r_pend_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_bot    <= '0;
      r_out_sel    <= 3'd7;
      r_out_extra  <= '0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_promote)        r_act_mask <= r_pend_mask;
      else if (w_load_act)  r_act_mask <= s_if.validBotPermutesIn;
      else if (w_emit)      r_act_mask <= w_rem_mask;

      if (w_load_pend)      r_pend_valid <= 1'b1;
      else if (w_promote)   r_pend_valid <= 1'b0;

      if (w_advance) begin
        if (w_act_valid) begin
          r_out_valid <= 1'b1;
          r_out_bot   <= f_permute(r_act_bot, w_sel);
          r_out_sel   <= w_sel;
          r_out_extra <= r_act_extra;
          r_out_last  <= (w_rem_mask == '0);
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  // NOTE: slot payloads are qualified by r_act_mask / r_pend_valid, so they
  // carry no reset; only the control and visible output state is reset.
  always_ff @(posedge clk) begin
    if (w_promote) begin
      r_act_bot   <= r_pend_bot;
      r_act_extra <= r_pend_extra;
    end else if (w_load_act) begin
      r_act_bot   <= s_if.botIn;
      r_act_extra <= s_if.extraDataIn;
    end
    if (w_load_pend) begin
      r_pend_mask  <= s_if.validBotPermutesIn;
      r_pend_bot   <= s_if.botIn;
      r_pend_extra <= s_if.extraDataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_if.inputReady             = w_in_ready;
  assign s_if.outputValid            = r_out_valid;
  assign s_if.permutedBot            = r_out_bot;
  assign s_if.selectedPermutationOut = r_out_sel;
  assign s_if.extraDataOut           = r_out_extra;
  assign s_if.lastOfBurst            = r_out_last;
  assign busy                        = w_act_valid | r_pend_valid | r_out_valid;

`ifdef BOT_PERMUTER_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics (wrap modulo 2^STAT_WIDTH)
  // ---------------------------------------------------------------------------
  logic [STAT_WIDTH-1:0] r_burst_cnt;
  logic [STAT_WIDTH-1:0] r_perm_cnt;
  logic [STAT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_burst_cnt <= '0;
      r_perm_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept_nz)                       r_burst_cnt <= r_burst_cnt + STAT_WIDTH'(1);
      if (r_out_valid &&  s_if.outputReady)  r_perm_cnt  <= r_perm_cnt  + STAT_WIDTH'(1);
      if (r_out_valid && !s_if.outputReady)  r_stall_cnt <= r_stall_cnt + STAT_WIDTH'(1);
    end
  end

  assign burstCount       = r_burst_cnt;
  assign permutationCount = r_perm_cnt;
  assign stallCycles      = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bot_permuter_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bot_permuter_stream
//   Self-checking bench for bot_permuter_stream. Two instances: VAR_COUNT=7
//   for the directed scenarios and VAR_COUNT=9 for a randomized stream
//   compared against a reference model. The reference treats a permutation
//   as a relabelling of the three top variables: output part p is the input
//   part whose variable bits are p's bits moved to their new positions.
// -----------------------------------------------------------------------------
module tb_bot_permuter_stream;

  localparam int EW = 12;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic busy7, busy9;

  bot_permuter_stream_if #(.VAR_COUNT(7), .EXTRA_DATA_WIDTH(EW)) if7 ();
  bot_permuter_stream_if #(.VAR_COUNT(9), .EXTRA_DATA_WIDTH(EW)) if9 ();

`ifdef BOT_PERMUTER_STATS_EN
  logic [31:0] bc7, pc7, sc7, bc9, pc9, sc9;
`endif

  bot_permuter_stream #(.VAR_COUNT(7), .EXTRA_DATA_WIDTH(EW)) u7 (
    .clk(clk), .rstn(rstn), .s_if(if7), .busy(busy7)
`ifdef BOT_PERMUTER_STATS_EN
    , .burstCount(bc7), .permutationCount(pc7), .stallCycles(sc7)
`endif
  );

  bot_permuter_stream #(.VAR_COUNT(9), .EXTRA_DATA_WIDTH(EW)) u9 (
    .clk(clk), .rstn(rstn), .s_if(if9), .busy(busy9)
`ifdef BOT_PERMUTER_STATS_EN
    , .burstCount(bc9), .permutationCount(pc9), .stallCycles(sc9)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [511:0] bot;
    logic [2:0]   sel;
    logic [EW-1:0] extra;
    logic         last;
  } exp_t;

  exp_t q9[$];

  // Reference: permutation k sends variable j to position ord[j].
  function automatic logic [511:0] ref_perm(input logic [511:0] bot, input int pw, input int k);
    int ord[3];
    int src;
    logic [511:0] res;
    case (k)
      5: begin ord[0] = 0; ord[1] = 1; ord[2] = 2; end
      4: begin ord[0] = 0; ord[1] = 2; ord[2] = 1; end
      3: begin ord[0] = 1; ord[1] = 0; ord[2] = 2; end
      2: begin ord[0] = 1; ord[1] = 2; ord[2] = 0; end
      1: begin ord[0] = 2; ord[1] = 0; ord[2] = 1; end
      default: begin ord[0] = 2; ord[1] = 1; ord[2] = 0; end
    endcase
    res = '0;
    for (int p = 0; p < 8; p++) begin
      src = 0;
      for (int j = 0; j < 3; j++) if (((p >> j) & 1) == 1) src = src | (1 << ord[j]);
      for (int b = 0; b < pw; b++) res[p*pw + b] = bot[src*pw + b];
    end
    return res;
  endfunction

  // Observed / expected output word of the VAR_COUNT=7 instance.
  function automatic logic [144:0] obs7();
    return {if7.outputValid, if7.selectedPermutationOut, if7.extraDataOut,
            if7.lastOfBurst, if7.permutedBot};
  endfunction

  function automatic logic [144:0] exp7(input logic [127:0] bot, input int k,
                                        input logic [EW-1:0] ex, input logic last);
    logic [511:0] r;
    r = ref_perm({384'b0, bot}, 16, k);
    return {1'b1, 3'(k), ex, last, r[127:0]};
  endfunction

  function automatic logic [127:0] rand_bot128();
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Offer one burst on the VAR_COUNT=7 stream; returns 1 ns after the accept
  // edge, with the number of cycles inputReady was low.
  task automatic send7(input logic [127:0] bot, input logic [5:0] mask,
                       input logic [EW-1:0] ex, output int waited);
    @(posedge clk); #1;
    if7.inputValid         = 1'b1;
    if7.botIn              = bot;
    if7.validBotPermutesIn = mask;
    if7.extraDataIn        = ex;
    waited = 0;
    @(negedge clk);
    while (!if7.inputReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!if7.inputReady) $display("FAIL send7_accept_timeout: inputReady stayed %b, required 1", if7.inputReady);
    else n_pass++;
    @(posedge clk); #1;
    if7.inputValid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #12;
    n_checks++;
    if ({if7.inputReady, obs7(), busy7} !== {1'b0, 1'b0, 3'd7, 12'h0, 1'b0, 128'h0, 1'b0})
      $display("FAIL reset_state: got ready=%b out=%h busy=%b, required ready=0 valid=0 sel=7 rest 0",
               if7.inputReady, obs7(), busy7);
    else n_pass++;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if7.inputReady, if7.outputValid, busy7} !== 3'b100)
      $display("FAIL reset_release: got ready/valid/busy=%b, required 100",
               {if7.inputReady, if7.outputValid, busy7});
    else n_pass++;
  endtask

  task automatic test_single_burst();
    logic [127:0] bot;
    logic [144:0] e;
    int w;
    for (int p = 0; p < 8; p++) bot[p*16 +: 16] = 16'(p * 16'h1111);
    if7.outputReady = 1'b1;
    send7(bot, 6'b111111, 12'h123, w);
    @(negedge clk);
    n_checks++;
    if (if7.outputValid !== 1'b0) $display("FAIL single_latency: outputValid=%b one cycle after accept, required 0", if7.outputValid);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp7(bot, 5 - i, 12'h123, i == 5);
      n_checks++;
      if (obs7() !== e) $display("FAIL single_out%0d: got %h required %h", i, obs7(), e);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({if7.outputValid, busy7} !== 2'b00)
      $display("FAIL single_drain: valid/busy=%b required 00", {if7.outputValid, busy7});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] ba, bb;
    logic [144:0] e;
    int w;
    ba = rand_bot128();
    bb = rand_bot128();
    if7.outputReady = 1'b1;
    send7(ba, 6'b100001, 12'h00A, w);
    if7.inputValid         = 1'b1;
    if7.botIn              = bb;
    if7.validBotPermutesIn = 6'b010000;
    if7.extraDataIn        = 12'h00B;
    @(negedge clk);
    n_checks++;
    if ({if7.inputReady, if7.outputValid} !== 2'b10)
      $display("FAIL b2b_second_offer: ready/valid=%b required 10", {if7.inputReady, if7.outputValid});
    else n_pass++;
    @(posedge clk); #1;
    if7.inputValid = 1'b0;
    @(negedge clk);
    e = exp7(ba, 5, 12'h00A, 1'b0);
    n_checks++;
    if ({if7.inputReady, obs7()} !== {1'b0, e})
      $display("FAIL b2b_out0: got ready=%b %h required ready=0 %h", if7.inputReady, obs7(), e);
    else n_pass++;
    @(negedge clk);
    e = exp7(ba, 0, 12'h00A, 1'b1);
    n_checks++;
    if ({if7.inputReady, obs7()} !== {1'b1, e})
      $display("FAIL b2b_out1: got ready=%b %h required ready=1 %h", if7.inputReady, obs7(), e);
    else n_pass++;
    @(negedge clk);
    e = exp7(bb, 4, 12'h00B, 1'b1);
    n_checks++;
    if (obs7() !== e) $display("FAIL b2b_out2: got %h required %h", obs7(), e);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({if7.outputValid, busy7} !== 2'b00)
      $display("FAIL b2b_drain: valid/busy=%b required 00", {if7.outputValid, busy7});
    else n_pass++;
  endtask

  task automatic test_zero_mask();
    int w;
    send7(rand_bot128(), 6'b000000, 12'h777, w);
    n_checks++;
    if (w !== 0) $display("FAIL zero_accept_wait: waited %0d cycles, required 0", w);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({if7.outputValid, busy7} !== 2'b00)
        $display("FAIL zero_idle%0d: valid/busy=%b required 00", i, {if7.outputValid, busy7});
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [127:0] bot;
    logic [144:0] e;
    int w;
`ifdef BOT_PERMUTER_STATS_EN
    logic [31:0] pc0, sc0;
    pc0 = pc7;
    sc0 = sc7;
`endif
    bot = rand_bot128();
    if7.outputReady = 1'b0;
    send7(bot, 6'b001100, 12'h3C3, w);
    @(negedge clk);
    n_checks++;
    if (if7.outputValid !== 1'b0) $display("FAIL stall_latency: outputValid=%b required 0", if7.outputValid);
    else n_pass++;
    e = exp7(bot, 3, 12'h3C3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs7() !== e) $display("FAIL stall_hold%0d: got %h required %h", i, obs7(), e);
      else n_pass++;
    end
    @(posedge clk); #1;
    if7.outputReady = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs7() !== e) $display("FAIL stall_release: got %h required %h", obs7(), e);
    else n_pass++;
    @(negedge clk);
    e = exp7(bot, 2, 12'h3C3, 1'b1);
    n_checks++;
    if (obs7() !== e) $display("FAIL stall_second: got %h required %h", obs7(), e);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if7.outputValid !== 1'b0) $display("FAIL stall_drain: outputValid=%b required 0", if7.outputValid);
    else n_pass++;
`ifdef BOT_PERMUTER_STATS_EN
    n_checks++;
    if ({sc7 - sc0, pc7 - pc0} !== {32'd5, 32'd2})
      $display("FAIL stall_stats: stall/perm deltas %0d/%0d required 5/2", sc7 - sc0, pc7 - pc0);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    logic [127:0] bot;
    logic [144:0] e;
    int w;
    if7.outputReady = 1'b1;
    send7(rand_bot128(), 6'b111111, 12'h0F0, w);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (if7.outputValid !== 1'b1) $display("FAIL areset_pre: outputValid=%b required 1", if7.outputValid);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({if7.inputReady, obs7(), busy7} !== {1'b0, 1'b0, 3'd7, 12'h0, 1'b0, 128'h0, 1'b0})
      $display("FAIL areset_state: got ready=%b out=%h busy=%b, required ready=0 valid=0 sel=7 rest 0",
               if7.inputReady, obs7(), busy7);
    else n_pass++;
`ifdef BOT_PERMUTER_STATS_EN
    n_checks++;
    if ({bc7, pc7, sc7} !== 96'h0) $display("FAIL areset_stats: got %h required 0", {bc7, pc7, sc7});
    else n_pass++;
`endif
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bot = rand_bot128();
    send7(bot, 6'b010010, 12'h5A5, w);
    @(negedge clk);
    n_checks++;
    if (if7.outputValid !== 1'b0) $display("FAIL areset_after_latency: outputValid=%b required 0", if7.outputValid);
    else n_pass++;
    @(negedge clk);
    e = exp7(bot, 4, 12'h5A5, 1'b0);
    n_checks++;
    if (obs7() !== e) $display("FAIL areset_after0: got %h required %h", obs7(), e);
    else n_pass++;
    @(negedge clk);
    e = exp7(bot, 1, 12'h5A5, 1'b1);
    n_checks++;
    if (obs7() !== e) $display("FAIL areset_after1: got %h required %h", obs7(), e);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({if7.outputValid, busy7} !== 2'b00)
      $display("FAIL areset_after_drain: valid/busy=%b required 00", {if7.outputValid, busy7});
    else n_pass++;
  endtask

  task automatic test_random_vc9();
    int   sent, cycles, n_exp, n_got, n_bursts_nz, n_stalls;
    logic acc, hs;
    exp_t x;
    logic [511:0] b;
    logic [5:0]   m;
`ifdef BOT_PERMUTER_STATS_EN
    logic [31:0] bc0, pc0, sc0;
    bc0 = bc9; pc0 = pc9; sc0 = sc9;
`endif
    sent = 0; cycles = 0; n_exp = 0; n_got = 0; n_bursts_nz = 0; n_stalls = 0;
    q9.delete();
    while ((sent < 40 || if9.inputValid || q9.size() > 0) && cycles < 4000) begin
      @(negedge clk);
      acc = if9.inputValid && if9.inputReady;
      hs  = if9.outputValid && if9.outputReady;
      if (if9.outputValid && !if9.outputReady) n_stalls++;
      if (hs) begin
        n_got++;
        n_checks++;
        if (q9.size() == 0) begin
          $display("FAIL rand_unexpected_output: sel=%0d with empty model queue", if9.selectedPermutationOut);
        end else begin
          x = q9.pop_front();
          if ({if9.selectedPermutationOut, if9.extraDataOut, if9.lastOfBurst, if9.permutedBot} !==
              {x.sel, x.extra, x.last, x.bot})
            $display("FAIL rand_out%0d: got sel=%0d ex=%h last=%b bot=%h required sel=%0d ex=%h last=%b bot=%h",
                     n_got, if9.selectedPermutationOut, if9.extraDataOut, if9.lastOfBurst,
                     if9.permutedBot, x.sel, x.extra, x.last, x.bot);
          else n_pass++;
        end
      end
      if (acc) begin
        m = if9.validBotPermutesIn;
        if (m != 6'b0) n_bursts_nz++;
        for (int k = 5; k >= 0; k--) begin
          if (m[k]) begin
            x.bot   = ref_perm(if9.botIn, 64, k);
            x.sel   = 3'(k);
            x.extra = if9.extraDataIn;
            x.last  = ((int'(m) & ((1 << k) - 1)) == 0);
            q9.push_back(x);
            n_exp++;
          end
        end
      end
      @(posedge clk); #1;
      if (acc) if9.inputValid = 1'b0;
      if (!if9.inputValid && sent < 40 && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        m = ($urandom_range(0, 7) == 0) ? 6'b0 : 6'($urandom);
        if9.inputValid         = 1'b1;
        if9.botIn              = b;
        if9.validBotPermutesIn = m;
        if9.extraDataIn        = 12'($urandom);
        sent++;
      end
      if9.outputReady = ($urandom_range(0, 3) != 0);
      cycles++;
    end
    n_checks++;
    if (cycles >= 4000) $display("FAIL rand_timeout: %0d bursts offered, %0d outputs pending", sent, q9.size());
    else n_pass++;
    n_checks++;
    if (n_got !== n_exp) $display("FAIL rand_count: got %0d outputs required %0d", n_got, n_exp);
    else n_pass++;
    if9.outputReady = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if9.outputValid, busy9} !== 2'b00)
      $display("FAIL rand_drain: valid/busy=%b required 00", {if9.outputValid, busy9});
    else n_pass++;
`ifdef BOT_PERMUTER_STATS_EN
    n_checks++;
    if ({bc9 - bc0, pc9 - pc0, sc9 - sc0} !== {32'(n_bursts_nz), 32'(n_got), 32'(n_stalls)})
      $display("FAIL rand_stats: got %0d/%0d/%0d required %0d/%0d/%0d",
               bc9 - bc0, pc9 - pc0, sc9 - sc0, n_bursts_nz, n_got, n_stalls);
    else n_pass++;
`endif
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    if7.inputValid = 1'b0; if7.botIn = '0; if7.validBotPermutesIn = '0;
    if7.extraDataIn = '0;  if7.outputReady = 1'b1;
    if9.inputValid = 1'b0; if9.botIn = '0; if9.validBotPermutesIn = '0;
    if9.extraDataIn = '0;  if9.outputReady = 1'b1;

    test_reset();
    test_single_burst();
    test_back_to_back();
    test_zero_mask();
    test_stall();
    test_async_reset();
    test_random_vc9();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
